// File: rtl/ir_pkg.sv
// Shared constants for the NEC receiver: pulse windows in microseconds,
// register map, CTRL/STATUS bit positions and the decoder state type.
package ir_pkg;
    typedef logic [13:0] us_t;

    localparam us_t LEAD_L_MIN = 14'd8000;
    localparam us_t LEAD_L_MAX = 14'd10000;
    localparam us_t LEAD_H_MIN = 14'd4000;
    localparam us_t LEAD_H_MAX = 14'd5000;
    localparam us_t REP_H_MIN  = 14'd2000;
    localparam us_t REP_H_MAX  = 14'd2500;
    localparam us_t BIT_L_MIN  = 14'd400;
    localparam us_t BIT_L_MAX  = 14'd700;
    localparam us_t BIT0_H_MIN = 14'd400;
    localparam us_t BIT0_H_MAX = 14'd700;
    localparam us_t BIT1_H_MIN = 14'd1400;
    localparam us_t BIT1_H_MAX = 14'd1900;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_THRESH = 3'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_CHK    = 2;
    localparam int CTRL_PREP   = 3;
    localparam int CTRL_FLUSH  = 4;

    localparam int ST_NE   = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_REP  = 3;
    localparam int ST_ERR  = 4;
    localparam int ST_LVL  = 8;

    typedef enum logic [2:0] {S_IDLE, S_LEAD_L, S_LEAD_H, S_BIT_L, S_BIT_H, S_REP_L} dec_state_t;

    function automatic logic in_win(input us_t w, input us_t lo, input us_t hi);
        return (w >= lo) && (w <= hi);
    endfunction
endpackage

// File: rtl/ir_nec_rx_fifo_if.sv
// Avalon-MM slave bus bundle for the NEC receiver register file.
interface ir_nec_rx_fifo_if;
    logic        avs_chipselect;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;

    modport master (output avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
                    input  avs_readdata);
    modport slave  (input  avs_chipselect, avs_address, avs_read, avs_write, avs_writedata,
                    output avs_readdata);
endinterface

// File: rtl/ir_nec_decoder.sv
// NEC frame decoder: input synchroniser, 1 us tick, phase-width counter and
// a state machine that judges each phase width when the phase ends.
module ir_nec_decoder
    import ir_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic        csi_CLK,
    input  logic        csi_RST,
    input  logic        en,
    input  logic        chk,
    input  logic        coe_iIRDA,
    output logic        code_valid,
    output logic [31:0] code,
    output logic        rep_pulse,
    output logic        err_pulse
);
    localparam int DIV = CLK_HZ / 1_000_000;
    localparam int DW  = $clog2(DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [1:0]    sync;
    logic          ir_q, fall, rise, tick;
    logic [DW-1:0] div_cnt;
    us_t           width;
    logic [5:0]    bcnt;
    logic [31:0]   shift;
    dec_state_t    state;

    always_ff @(posedge csi_CLK or posedge csi_RST) begin
        if (csi_RST) begin
            sync <= 2'b11;
            ir_q <= 1'b1;
        end else begin
            sync <= {sync[0], coe_iIRDA};
            ir_q <= sync[1];
        end
    end

    assign fall = ir_q & ~sync[1];
    assign rise = ~ir_q & sync[1];
    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge csi_CLK or posedge csi_RST) begin
        if (csi_RST)   div_cnt <= '0;
        else if (tick) div_cnt <= '0;
        else           div_cnt <= div_cnt + 1'b1;
    end

    // Width of the current phase in us; saturates so long idles never wrap.
    always_ff @(posedge csi_CLK or posedge csi_RST) begin
        if (csi_RST)                      width <= '0;
        else if (fall | rise)             width <= '0;
        else if (tick && width != '1)     width <= width + 1'b1;
    end

    always_ff @(posedge csi_CLK or posedge csi_RST) begin
        if (csi_RST) begin
            state      <= S_IDLE;
            bcnt       <= '0;
            shift      <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            rep_pulse  <= 1'b0;
            err_pulse  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            rep_pulse  <= 1'b0;
            err_pulse  <= 1'b0;
            if (!en) state <= S_IDLE;
            else begin
                case (state)
                    S_IDLE: if (fall) state <= S_LEAD_L;
                    S_LEAD_L:
                        if (rise) state <= in_win(width, LEAD_L_MIN, LEAD_L_MAX) ? S_LEAD_H : S_IDLE;
                        else if (width > LEAD_L_MAX) state <= S_IDLE;
                    S_LEAD_H:
                        if (fall) begin
                            if (in_win(width, LEAD_H_MIN, LEAD_H_MAX)) begin
                                state <= S_BIT_L;
                                bcnt  <= '0;
                            end else if (in_win(width, REP_H_MIN, REP_H_MAX)) state <= S_REP_L;
                            else state <= S_IDLE;
                        end else if (width > LEAD_H_MAX) state <= S_IDLE;
                    S_BIT_L:
                        if (rise) begin
                            if (!in_win(width, BIT_L_MIN, BIT_L_MAX)) state <= S_IDLE;
                            else if (bcnt[5]) begin
                                // Stop burst after 32 bits; only the command byte pair is checked.
                                state <= S_IDLE;
                                if (!chk || shift[23:16] == ~shift[31:24]) begin
                                    code_valid <= 1'b1;
                                    code       <= shift;
                                end else err_pulse <= 1'b1;
                            end else state <= S_BIT_H;
                        end else if (width > BIT_L_MAX) state <= S_IDLE;
                    S_BIT_H:
                        if (fall) begin
                            if (in_win(width, BIT0_H_MIN, BIT0_H_MAX)) begin
                                shift[bcnt[4:0]] <= 1'b0;
                                bcnt  <= bcnt + 1'b1;
                                state <= S_BIT_L;
                            end else if (in_win(width, BIT1_H_MIN, BIT1_H_MAX)) begin
                                shift[bcnt[4:0]] <= 1'b1;
                                bcnt  <= bcnt + 1'b1;
                                state <= S_BIT_L;
                            end else state <= S_IDLE;
                        end else if (width > BIT1_H_MAX) state <= S_IDLE;
                    S_REP_L:
                        if (rise) begin
                            rep_pulse <= in_win(width, BIT_L_MIN, BIT_L_MAX);
                            state     <= S_IDLE;
                        end else if (width > BIT_L_MAX) state <= S_IDLE;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/ir_nec_rx_fifo.sv
// NEC IR receiver with code FIFO, Avalon-MM register file and level interrupt.
module ir_nec_rx_fifo
    import ir_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              csi_CLK,
    input  logic              csi_RST,
    ir_nec_rx_fifo_if.slave   avs,
    output logic              ins_irq,
    input  logic              coe_iIRDA
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic             ctrl_en, ctrl_irq_en, ctrl_chk, ctrl_prep, flush_q;
    logic [LVL_W-1:0] thresh, thr_eff, level;
    logic             st_ovf, st_rep, st_err;
    logic [31:0]      last_code, push_data, rdata, dec_code;
    logic             last_vld, dec_valid, dec_rep, dec_err;
    logic [31:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             wr, rd, wr_st, empty, full, push, push_ok, pop;
    logic             unused_wd;

    ir_nec_decoder #(.CLK_HZ(CLK_HZ)) u_dec (
        .csi_CLK    (csi_CLK),
        .csi_RST    (csi_RST),
        .en         (ctrl_en),
        .chk        (ctrl_chk),
        .coe_iIRDA  (coe_iIRDA),
        .code_valid (dec_valid),
        .code       (dec_code),
        .rep_pulse  (dec_rep),
        .err_pulse  (dec_err)
    );

    assign wr        = avs.avs_chipselect & avs.avs_write;
    assign rd        = avs.avs_chipselect & avs.avs_read;
    assign wr_st     = wr & (avs.avs_address == ADDR_STATUS);
    assign empty     = (level == '0);
    assign full      = (level == LVL_W'(FIFO_DEPTH));
    assign push      = dec_valid | (dec_rep & ctrl_prep & last_vld);
    assign push_data = dec_valid ? dec_code : last_code;
    assign push_ok   = push & ~full & ~flush_q;
    assign pop       = rd & (avs.avs_address == ADDR_DATA) & ~empty & ~flush_q;
    assign thr_eff   = (thresh == '0) ? LVL_W'(1) : thresh;
    assign unused_wd = &{1'b0, avs.avs_writedata};

    always_comb begin
        rdata = '0;
        case (avs.avs_address)
            ADDR_DATA:   if (!empty) rdata = mem[rp];
            ADDR_STATUS: begin
                rdata[ST_NE]            = ~empty;
                rdata[ST_FULL]          = full;
                rdata[ST_OVF]           = st_ovf;
                rdata[ST_REP]           = st_rep;
                rdata[ST_ERR]           = st_err;
                rdata[ST_LVL +: LVL_W]  = level;
            end
            ADDR_CTRL:   rdata[3:0] = {ctrl_prep, ctrl_chk, ctrl_irq_en, ctrl_en};
            ADDR_THRESH: rdata[LVL_W-1:0] = thresh;
            default: ;
        endcase
    end

    always_ff @(posedge csi_CLK) if (push_ok) mem[wp] <= push_data;

    always_ff @(posedge csi_CLK or posedge csi_RST) begin
        if (csi_RST) begin
            wp <= '0; rp <= '0; level <= '0;
        end else if (flush_q) begin
            wp <= '0; rp <= '0; level <= '0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge csi_CLK or posedge csi_RST) begin
        if (csi_RST) begin
            ctrl_en          <= 1'b1;
            ctrl_irq_en      <= 1'b1;
            ctrl_chk         <= 1'b1;
            ctrl_prep        <= 1'b0;
            flush_q          <= 1'b0;
            thresh           <= LVL_W'(1);
            st_ovf           <= 1'b0;
            st_rep           <= 1'b0;
            st_err           <= 1'b0;
            last_code        <= '0;
            last_vld         <= 1'b0;
            avs.avs_readdata <= '0;
            ins_irq          <= 1'b0;
        end else begin
            flush_q <= wr && avs.avs_address == ADDR_CTRL && avs.avs_writedata[CTRL_FLUSH];
            if (wr && avs.avs_address == ADDR_CTRL) begin
                ctrl_en     <= avs.avs_writedata[CTRL_EN];
                ctrl_irq_en <= avs.avs_writedata[CTRL_IRQ_EN];
                ctrl_chk    <= avs.avs_writedata[CTRL_CHK];
                ctrl_prep   <= avs.avs_writedata[CTRL_PREP];
            end
            if (wr && avs.avs_address == ADDR_THRESH) thresh <= avs.avs_writedata[LVL_W-1:0];
            // New events win over a simultaneous write-1-to-clear.
            st_ovf <= (st_ovf & ~(wr_st & avs.avs_writedata[ST_OVF])) | (push & full & ~flush_q);
            st_rep <= (st_rep & ~(wr_st & avs.avs_writedata[ST_REP])) | dec_rep;
            st_err <= (st_err & ~(wr_st & avs.avs_writedata[ST_ERR])) | dec_err;
            if (dec_valid) begin
                last_code <= dec_code;
                last_vld  <= 1'b1;
            end
            if (rd) avs.avs_readdata <= rdata;
            ins_irq <= ctrl_irq_en & ((level >= thr_eff) | st_ovf);
        end
    end
endmodule

// File: tb/tb_ir_nec_rx_fifo.sv
// Directed bench for ir_nec_rx_fifo: 2 MHz clock (2 cycles/us), 4-entry FIFO.
`timescale 1ns/1ps
module tb_ir_nec_rx_fifo;
    localparam int DEPTH = 4;
    localparam int US    = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ir  = 1'b1;
    logic irq;
    int   n_pass = 0;
    int   n_chk  = 0;

    ir_nec_rx_fifo_if avs();

    ir_nec_rx_fifo #(.CLK_HZ(2_000_000), .FIFO_DEPTH(DEPTH)) dut (
        .csi_CLK   (clk),
        .csi_RST   (rst),
        .avs       (avs),
        .ins_irq   (irq),
        .coe_iIRDA (ir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic bus_rd(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        avs.avs_chipselect = 1'b1; avs.avs_read = 1'b1; avs.avs_address = a;
        @(negedge clk);
        avs.avs_chipselect = 1'b0; avs.avs_read = 1'b0;
        d = avs.avs_readdata;
    endtask

    task automatic bus_wr(input logic [2:0] a, input logic [31:0] v);
        @(negedge clk);
        avs.avs_chipselect = 1'b1; avs.avs_write = 1'b1; avs.avs_address = a; avs.avs_writedata = v;
        @(negedge clk);
        avs.avs_chipselect = 1'b0; avs.avs_write = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_rd(a, d);
        check(tag, d, exp);
    endtask

    task automatic mark(input int lo, input int hi);
        ir = 1'b0; #(lo * US);
        ir = 1'b1; #(hi * US);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        mark(8500, 4200);
        for (int i = 0; i < nbits; i++) mark(450, w[i] ? 1450 : 450);
    endtask

    task automatic send_frame(input logic [31:0] w);
        send_bits(w, 32);
        mark(450, 50);
    endtask

    task automatic send_repeat();
        mark(8500, 2100);
        mark(450, 50);
    endtask

    initial begin
        avs.avs_chipselect = 1'b0; avs.avs_read = 1'b0; avs.avs_write = 1'b0;
        avs.avs_address = 3'd0; avs.avs_writedata = 32'd0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_readdata", avs.avs_readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rd_chk("rst_status", 3'd1, 32'h0);
        rd_chk("rst_ctrl", 3'd2, 32'h7);
        rd_chk("rst_thresh", 3'd3, 32'h1);
        rd_chk("empty_data", 3'd0, 32'h0);
        rd_chk("hole_reg", 3'd5, 32'h0);

        // 1: basic frame, irq follows level
        send_frame(32'hBA45FF00);
        @(negedge clk);
        check("t1_irq_hi", 32'(irq), 32'h1);
        rd_chk("t1_status", 3'd1, 32'h101);
        rd_chk("t1_data", 3'd0, 32'hBA45FF00);
        check("t1_irq_hold", 32'(irq), 32'h1);
        @(negedge clk);
        check("t1_irq_lo", 32'(irq), 32'h0);
        rd_chk("t1_status2", 3'd1, 32'h0);

        // 2: bad inverse byte with and without checking
        send_frame(32'h0045FF00);
        rd_chk("t2_err", 3'd1, 32'h10);
        bus_wr(3'd2, 32'h3);
        send_frame(32'h0045FF00);
        rd_chk("t2_nochk", 3'd1, 32'h111);
        bus_wr(3'd1, 32'h10);
        rd_chk("t2_errclr", 3'd1, 32'h101);
        rd_chk("t2_data", 3'd0, 32'h0045FF00);
        bus_wr(3'd2, 32'h7);

        // 3: repeat codes, prep off then on
        send_frame(32'h00FF0001);
        send_repeat();
        rd_chk("t3_noprep", 3'd1, 32'h109);
        bus_wr(3'd1, 32'h08);
        bus_wr(3'd2, 32'hF);
        for (int k = 0; k < 3; k++) send_repeat();
        rd_chk("t3_prep", 3'd1, 32'h40B);
        for (int k = 0; k < 4; k++) rd_chk("t3_entry", 3'd0, 32'h00FF0001);
        bus_wr(3'd1, 32'h08);
        bus_wr(3'd2, 32'h7);

        // 4: overflow
        for (int k = 1; k <= DEPTH + 2; k++) send_frame({24'h00FF00, 8'(k)});
        rd_chk("t4_status", 3'd1, 32'h407);
        check("t4_irq", 32'(irq), 32'h1);
        for (int k = 1; k <= DEPTH; k++) rd_chk("t4_order", 3'd0, {24'h00FF00, 8'(k)});
        rd_chk("t4_empty_rd", 3'd0, 32'h0);
        rd_chk("t4_ovf_sticky", 3'd1, 32'h004);
        check("t4_irq_ovf", 32'(irq), 32'h1);
        bus_wr(3'd1, 32'h04);
        @(negedge clk);
        check("t4_irq_clr", 32'(irq), 32'h0);

        // 5: truncated frame times out without a push
        send_bits(32'h00FF0005, 20);
        #(2000 * US);
        rd_chk("t5_nopush", 3'd1, 32'h0);
        send_frame(32'h00FF0006);
        rd_chk("t5_status", 3'd1, 32'h101);
        rd_chk("t5_data", 3'd0, 32'h00FF0006);

        // 6: reset mid-frame, threshold, flush
        bus_wr(3'd2, 32'hF);
        send_repeat();
        rd_chk("t6_prerst", 3'd1, 32'h109);
        bus_wr(3'd3, 32'h2);
        send_bits(32'h00FF0007, 10);
        @(negedge clk);
        rst = 1'b1;
        #100;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_rst_rdata", avs.avs_readdata, 32'h0);
        check("t6_rst_irq", 32'(irq), 32'h0);
        rd_chk("t6_rst_status", 3'd1, 32'h0);
        rd_chk("t6_rst_ctrl", 3'd2, 32'h7);
        rd_chk("t6_rst_thresh", 3'd3, 32'h1);
        bus_wr(3'd2, 32'hF);
        send_repeat();
        rd_chk("t6_no_last", 3'd1, 32'h08);
        bus_wr(3'd1, 32'h08);
        bus_wr(3'd2, 32'h7);
        bus_wr(3'd3, 32'h3);
        send_frame(32'h00FF0007);
        send_frame(32'h00FF0008);
        @(negedge clk);
        check("t6_irq_below", 32'(irq), 32'h0);
        rd_chk("t6_lvl2", 3'd1, 32'h201);
        send_frame(32'h00FF0009);
        @(negedge clk);
        check("t6_irq_at", 32'(irq), 32'h1);
        bus_wr(3'd2, 32'h17);
        @(negedge clk);
        @(negedge clk);
        check("t6_irq_flush", 32'(irq), 32'h0);
        rd_chk("t6_flushed", 3'd1, 32'h0);
        rd_chk("t6_ctrl_sc", 3'd2, 32'h7);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
